// File: rtl/shift_add_multiplier_if.sv
// rtl/shift_add_multiplier_if.sv - request/result bundle for the shift-add multiplier
interface shift_add_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     P;

  modport master (
    output start, signed_mode, A, B,
    input  busy, done, P
  );

  modport slave (
    input  start, signed_mode, A, B,
    output busy, done, P
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - iterative sign-magnitude shift-and-add multiplier, one bit per cycle
module shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_add_multiplier_if.slave mul
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mcand_q;
  logic                 sign_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   p_q;

  logic [WIDTH-1:0]     a_mag_d;
  logic [WIDTH-1:0]     b_mag_d;
  logic [WIDTH:0]       sum_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   prod_d;

  // The most-negative operand negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    a_mag_d = mul.A;
    b_mag_d = mul.B;
    if (mul.signed_mode && mul.A[WIDTH-1]) a_mag_d = '0 - mul.A;
    if (mul.signed_mode && mul.B[WIDTH-1]) b_mag_d = '0 - mul.B;
  end

  always_comb begin
    sum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
    acc_d  = {sum_d, acc_q[WIDTH-1:1]};
    prod_d = sign_q ? ('0 - acc_d) : acc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (mul.start) begin
            mcand_q <= a_mag_d;
            acc_q   <= {{WIDTH{1'b0}}, b_mag_d};
            sign_q  <= mul.signed_mode & (mul.A[WIDTH-1] ^ mul.B[WIDTH-1]);
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          // Last iteration: the product is taken from the freshly shifted accumulator.
          if (cnt_q == CW'(1)) begin
            p_q     <= prod_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mul.busy = busy_q;
  assign mul.done = done_q;
  assign mul.P    = p_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed and randomized checks of shift_add_multiplier against an arithmetic model
module tb_shift_add_multiplier;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  shift_add_multiplier_if #(.WIDTH(W)) mif ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .mul (mif)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic sm);
    longint sa;
    longint sb;
    if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Called just after a negedge with the DUT idle; returns one negedge after the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sm,
                        input bit noise, input string tag);
    logic [63:0] exp;
    logic [63:0] p_hold;
    int          n;
    bit          stable;
    exp = ref_prod(a, b, sm);
    mif.start       = 1'b1;
    mif.A           = a;
    mif.B           = b;
    mif.signed_mode = sm;
    @(negedge clk);
    mif.start       = noise;
    mif.A           = $urandom;
    mif.B           = $urandom;
    mif.signed_mode = ~sm;
    p_hold = mif.P;
    n      = 0;
    stable = 1'b1;
    while (mif.busy === 1'b1 && n < 4 * W) begin
      n++;
      if (mif.P !== p_hold) stable = 1'b0;
      if (noise) begin
        mif.start = 1'($urandom_range(0, 1));
        mif.A     = $urandom;
        mif.B     = $urandom;
      end
      @(negedge clk);
    end
    mif.start = 1'b0;
    check({tag, ":busy_cycles"}, 64'(n), 64'(W));
    check({tag, ":p_stable"}, 64'(stable), 64'd1);
    check({tag, ":done"}, 64'(mif.done), 64'd1);
    check({tag, ":P"}, mif.P, exp);
    @(negedge clk);
    check({tag, ":done_busy_low"}, {62'b0, mif.done, mif.busy}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pulses;
    logic [31:0] ra;
    logic [31:0] rb;
    rst             = 1'b1;
    mif.start       = 1'b0;
    mif.signed_mode = 1'b0;
    mif.A           = '0;
    mif.B           = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {mif.P[61:0], mif.done, mif.busy}, 64'd0);
    check("reset_P", mif.P, 64'd0);
    rst = 1'b0;

    run_op(32'd3, 32'd5, 1'b0, 1'b0, "u3x5");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "umax");
    check("umax_const", mif.P, 64'hFFFF_FFFE_0000_0001);
    run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, "s_m3x7");
    check("s_m3x7_const", mif.P, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, "s_minxmin");
    check("s_minxmin_const", mif.P, 64'h4000_0000_0000_0000);
    run_op(32'd2, 32'd2, 1'b0, 1'b1, "start_ignored");
    check("start_ignored_const", mif.P, 64'h4);

    // Abort a multiply in its tenth RUN cycle with an asynchronous reset.
    mif.start       = 1'b1;
    mif.A           = 32'd11;
    mif.B           = 32'd13;
    mif.signed_mode = 1'b0;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", 64'(mif.busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_async_clear", {mif.P[61:0], mif.done, mif.busy}, 64'd0);
    check("abort_async_P", mif.P, 64'd0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (mif.done === 1'b1 || mif.busy === 1'b1) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);

    // Start on the first edge after reset releases.
    rst = 1'b1;
    #1 rst = 1'b0;
    run_op(32'd6, 32'd7, 1'b0, 1'b0, "after_reset");
    check("after_reset_const", mif.P, 64'h2A);

    run_op(32'd1, 32'd0, 1'b0, 1'b0, "b2b_first");
    run_op(32'h10, 32'h10, 1'b0, 1'b0, "b2b_second");
    check("b2b_second_const", mif.P, 64'h100);
    run_op(32'd0, 32'h8000_0001, 1'b1, 1'b0, "zero_neg_b");
    run_op(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, "neg_a_zero");
    check("neg_a_zero_const", mif.P, 64'd0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 0) ra = 32'h8000_0000;
      if (i % 7 == 3) rb = 32'h7FFF_FFFF;
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; product width is 2*WIDTH.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request a multiply; sampled on the rising edge of clk.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with the operands.
REQ-006 SHALL have port A  input  WIDTH  multiplicand.
REQ-007 SHALL have port B  input  WIDTH  multiplier.
REQ-008 SHALL have port busy  output  1  high while a multiply is in progress (state RUN).
REQ-009 SHALL have port done  output  1  one-cycle pulse marking P valid.
REQ-010 SHALL have port P  output  2*WIDTH  product; registered.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FIN.
REQ-012 SHALL accept start only in IDLE: at that edge it captures A, B and signed_mode, loads the iteration counter with WIDTH, clears the partial-sum high half, and moves to RUN.
REQ-013 SHALL ignore start while in RUN or FIN; operand changes after the accepting edge SHALL NOT affect the result.
REQ-014 SHALL, in signed mode, convert captured operands to magnitudes at acceptance (0 - x when the MSB is set) and record sign = A[MSB] XOR B[MSB]; in unsigned mode sign = 0 and operands are used as-is.
REQ-015 SHALL, each RUN cycle, add the multiplicand magnitude to the high half when the multiplier LSB is 1 (else add 0) using one WIDTH-bit adder with carry-in 0, then shift {carry-out, high half, low half} right by one bit into the 2*WIDTH accumulator.
REQ-016 SHALL decrement the counter each RUN cycle and move to FIN on the edge where the counter reaches 0, i.e. after exactly WIDTH RUN cycles.
REQ-017 SHALL, on entering FIN, load P with the accumulator, or its two's-complement negation (mod 2^(2*WIDTH)) when sign = 1.
REQ-018 SHALL assert done for exactly the one FIN cycle, then return to IDLE; latency from accepting edge to done high is WIDTH+1 cycles.
REQ-019 SHALL hold P stable from FIN until the next FIN; P SHALL NOT change during RUN.
REQ-020 SHALL produce the exact 2*WIDTH-bit product for all operand pairs, including the most-negative value in signed mode (magnitude 2^(WIDTH-1) treated as unsigned).
REQ-021 SHALL allow back-to-back operation: start high in the IDLE cycle immediately after FIN is accepted.
REQ-022 SHALL yield P = 0 when either operand is 0, regardless of sign.

Reset
REQ-023 SHALL, on rst high, immediately force state IDLE, busy = 0, done = 0, P = 0, counter and accumulator = 0, independent of clk.
REQ-024 SHALL abort any in-progress multiply on reset; no done pulse SHALL follow for the aborted operation.
REQ-025 SHALL accept a new start on the first rising edge after rst deasserts.

Verification
REQ-026 SHALL pass: unsigned A=3, B=5, start 1 cycle -> busy for 32 cycles, done at cycle 33, P=0x000000000000000F.
REQ-027 SHALL pass: unsigned A=B=0xFFFFFFFF -> P=0xFFFFFFFE00000001.
REQ-028 SHALL pass: signed A=0xFFFFFFFD (-3), B=7 -> P=0xFFFFFFFFFFFFFFEB; signed A=B=0x80000000 -> P=0x4000000000000000.
REQ-029 SHALL pass: start A=2,B=2, then start A=9,B=9 asserted during RUN -> single done, P=0x4; second start has no effect.
REQ-030 SHALL pass: rst pulse at RUN cycle 10 -> busy, done, P go 0 asynchronously, no done pulse afterwards; next start A=6,B=7 -> P=0x2A.
REQ-031 SHALL pass: two consecutive operations (A=1,B=0 then A=0x10,B=0x10) with start in the cycle after done -> P=0 then P=0x100, each done exactly one cycle.
